// File: rtl/alu_pkg.sv
// +----------------------------------------------------------------------------+
// | alu_pkg : shared width constants and opcode / shift-type encodings for   |
// |           the registered two-operand ALU.                                  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

package alu_pkg;

  localparam int ALU_WIDTH   = 32;
  localparam int ALU_SHAMT_W = $clog2(ALU_WIDTH);

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_XOR = 3'd3,
    ALU_SLL = 3'd4,
    ALU_SRL = 3'd5,
    ALU_SRA = 3'd6,
    ALU_OR  = 3'd7
  } alu_op_t;

  typedef enum logic [1:0] {
    SH_SLL  = 2'd0,
    SH_SRL  = 2'd1,
    SH_SRA  = 2'd2,
    SH_RSVD = 2'd3
  } shift_t;

  // Shift opcodes 4..6 carry their shift type in the low two bits.
  function automatic shift_t op_to_shift(input alu_op_t op);
    return shift_t'(op[1:0]);
  endfunction

endpackage

`default_nettype wire

// File: rtl/alu_shifter.sv
// +----------------------------------------------------------------------------+
// | alu_shifter : combinational log-stage barrel shifter for SLL/SRL/SRA.    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module alu_shifter
  import alu_pkg::*;
#(
  parameter int WIDTH   = ALU_WIDTH,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0]   data,
  input  logic [SHAMT_W-1:0] shamt,
  input  shift_t             shift_type,
  output logic [WIDTH-1:0]   result
);

  logic             w_left;
  logic             w_fill;
  logic [WIDTH-1:0] w_data_rev;
  logic [WIDTH-1:0] w_out_rev;
  logic [WIDTH-1:0] w_stage [0:SHAMT_W];

  assign w_left = (shift_type == SH_SLL);
  assign w_fill = (shift_type == SH_SRA) & data[WIDTH-1];

  // Left shifts reuse the right-shift network by mirroring the word in and out.
  for (genvar k = 0; k < WIDTH; k++) begin : g_rev
    assign w_data_rev[k] = data[WIDTH-1-k];
    assign w_out_rev[k]  = w_stage[SHAMT_W][WIDTH-1-k];
  end

  assign w_stage[0] = w_left ? w_data_rev : data;

  for (genvar i = 0; i < SHAMT_W; i++) begin : g_stage
    localparam int STEP = 1 << i;
    assign w_stage[i+1] = shamt[i]
                        ? {{STEP{w_fill}}, w_stage[i][WIDTH-1:STEP]}
                        : w_stage[i];
  end

  assign result = w_left ? w_out_rev : w_stage[SHAMT_W];

endmodule

`default_nettype wire

// File: rtl/alu_2to1_reg.sv
// +----------------------------------------------------------------------------+
// | alu_2to1_reg : 32-bit two-operand ALU with registered result and flags.  |
// | Build option: define ALU_FLAGS_EN to generate Zero/Negative/Carry/Overflow|
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module alu_2to1_reg
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] In_A,
  input  logic [WIDTH-1:0] In_B,
  input  logic [2:0]       ALUControl,
  output logic [WIDTH-1:0] Out_ALU,
  output logic             Zero,
  output logic             Negative,
  output logic             Carry,
  output logic             Overflow
);

  localparam int SHAMT_W = $clog2(WIDTH);

  alu_op_t          w_op;
  logic             w_is_sub;
  logic [WIDTH-1:0] w_b_op;
  logic [WIDTH-1:0] w_sum;
  logic [WIDTH-1:0] w_shift;
  logic [WIDTH-1:0] w_result;
  logic [WIDTH-1:0] r_result;

  assign w_op     = alu_op_t'(ALUControl);
  assign w_is_sub = (w_op == ALU_SUB);
  assign w_b_op   = w_is_sub ? ~In_B : In_B;

  alu_shifter #(
    .WIDTH   (WIDTH),
    .SHAMT_W (SHAMT_W)
  ) u_shifter (
    .data       (In_A),
    .shamt      (In_B[SHAMT_W-1:0]),
    .shift_type (op_to_shift(w_op)),
    .result     (w_shift)
  );

  always_comb begin
    w_result = '0;
    case (w_op)
      ALU_ADD,
      ALU_SUB: w_result = w_sum;
      ALU_AND: w_result = In_A & In_B;
      ALU_XOR: w_result = In_A ^ In_B;
      ALU_SLL,
      ALU_SRL,
      ALU_SRA: w_result = w_shift;
      ALU_OR:  w_result = In_A | In_B;
      default: w_result = '0;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_result <= '0;
    end else begin
      r_result <= w_result;
    end
  end

  assign Out_ALU = r_result;

`ifdef ALU_FLAGS_EN
  logic w_carry;
  logic w_arith;
  logic w_ovf;
  logic r_zero;
  logic r_negative;
  logic r_carry;
  logic r_overflow;

  // Subtract is A + ~B + 1, so the adder carry-out is directly "no borrow".
  assign {w_carry, w_sum} = {1'b0, In_A} + {1'b0, w_b_op} + {{WIDTH{1'b0}}, w_is_sub};
  assign w_arith = (w_op == ALU_ADD) || w_is_sub;
  // Operands entering the adder share a sign but the sum's sign differs.
  assign w_ovf   = (In_A[WIDTH-1] == w_b_op[WIDTH-1]) && (w_sum[WIDTH-1] != In_A[WIDTH-1]);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_zero     <= 1'b1;
      r_negative <= 1'b0;
      r_carry    <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_zero     <= (w_result == '0);
      r_negative <= w_result[WIDTH-1];
      r_carry    <= w_arith & w_carry;
      r_overflow <= w_arith & w_ovf;
    end
  end

  assign Zero     = r_zero;
  assign Negative = r_negative;
  assign Carry    = r_carry;
  assign Overflow = r_overflow;
`else
  assign w_sum    = In_A + w_b_op + {{(WIDTH-1){1'b0}}, w_is_sub};
  assign Zero     = 1'b0;
  assign Negative = 1'b0;
  assign Carry    = 1'b0;
  assign Overflow = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_alu_2to1_reg.sv
// +----------------------------------------------------------------------------+
// | tb_alu_2to1_reg : directed self-checking bench for alu_2to1_reg.          |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module tb_alu_2to1_reg;

`ifdef ALU_FLAGS_EN
  localparam bit FL = 1'b1;
`else
  localparam bit FL = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [31:0] In_A = '0;
  logic [31:0] In_B = '0;
  logic [2:0]  ALUControl = 3'd0;
  logic [31:0] Out_ALU;
  logic        Zero, Negative, Carry, Overflow;

  int n_cmp  = 0;
  int n_fail = 0;

  alu_2to1_reg dut (
    .CLK        (CLK),
    .RST        (RST),
    .In_A       (In_A),
    .In_B       (In_B),
    .ALUControl (ALUControl),
    .Out_ALU    (Out_ALU),
    .Zero       (Zero),
    .Negative   (Negative),
    .Carry      (Carry),
    .Overflow   (Overflow)
  );

  always #5 CLK = ~CLK;

  // Drive at the falling edge, then observe 1ns after the capturing edge.
  task automatic drive_op(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
    @(negedge CLK);
    In_A = a; In_B = b; ALUControl = op;
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset;
    In_A = 32'h1; In_B = 32'h1; ALUControl = 3'd0;
    RST = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    n_cmp++; if (Out_ALU !== 32'h0) begin n_fail++; $display("FAIL reset_out got %h want %h", Out_ALU, 32'h0); end
    n_cmp++; if (Zero !== FL) begin n_fail++; $display("FAIL reset_zero got %b want %b", Zero, FL); end
    n_cmp++; if ({Negative, Carry, Overflow} !== 3'b000) begin n_fail++; $display("FAIL reset_nco got %b want 000", {Negative, Carry, Overflow}); end
    @(negedge CLK);
    RST = 1'b0;
  endtask

  task automatic test_add_sub;
    drive_op(32'd10, 32'd4, 3'd0);
    n_cmp++; if (Out_ALU !== 32'd14) begin n_fail++; $display("FAIL add_10_4 got %h want %h", Out_ALU, 32'd14); end
    n_cmp++; if ({Zero, Negative, Carry, Overflow} !== 4'b0000) begin n_fail++; $display("FAIL add_10_4_flags got %b want 0000", {Zero, Negative, Carry, Overflow}); end
    @(negedge CLK);
    In_A = 32'd10; In_B = 32'd4; ALUControl = 3'd1;
    #1;
    n_cmp++; if (Out_ALU !== 32'd14) begin n_fail++; $display("FAIL sub_latency got %h want %h", Out_ALU, 32'd14); end
    @(posedge CLK);
    #1;
    n_cmp++; if (Out_ALU !== 32'd6) begin n_fail++; $display("FAIL sub_10_4 got %h want %h", Out_ALU, 32'd6); end
    n_cmp++; if ({Carry, Overflow} !== {FL, 1'b0}) begin n_fail++; $display("FAIL sub_10_4_cv got %b want %b", {Carry, Overflow}, {FL, 1'b0}); end
  endtask

  task automatic test_negative;
    drive_op(32'd10, 32'hFFFFFFD0, 3'd0);
    n_cmp++; if (Out_ALU !== 32'hFFFFFFDA) begin n_fail++; $display("FAIL add_neg got %h want %h", Out_ALU, 32'hFFFFFFDA); end
    n_cmp++; if ({Zero, Negative, Carry, Overflow} !== {1'b0, FL, 2'b00}) begin n_fail++; $display("FAIL add_neg_flags got %b want %b", {Zero, Negative, Carry, Overflow}, {1'b0, FL, 2'b00}); end
    drive_op(32'd10, 32'hFFFFFFD0, 3'd1);
    n_cmp++; if (Out_ALU !== 32'd58) begin n_fail++; $display("FAIL sub_neg got %h want %h", Out_ALU, 32'd58); end
    n_cmp++; if ({Zero, Negative, Carry, Overflow} !== 4'b0000) begin n_fail++; $display("FAIL sub_neg_flags got %b want 0000", {Zero, Negative, Carry, Overflow}); end
  endtask

  task automatic test_logic;
    drive_op(32'h0000FFFF, 32'h00001000, 3'd2);
    n_cmp++; if (Out_ALU !== 32'h00001000) begin n_fail++; $display("FAIL and got %h want %h", Out_ALU, 32'h00001000); end
    drive_op(32'h0000FFFF, 32'hFFFFFFFF, 3'd3);
    n_cmp++; if (Out_ALU !== 32'hFFFF0000) begin n_fail++; $display("FAIL xor got %h want %h", Out_ALU, 32'hFFFF0000); end
    n_cmp++; if ({Negative, Carry, Overflow} !== {FL, 2'b00}) begin n_fail++; $display("FAIL xor_flags got %b want %b", {Negative, Carry, Overflow}, {FL, 2'b00}); end
    drive_op(32'h0000FFFF, 32'hFFFFFFFF, 3'd7);
    n_cmp++; if (Out_ALU !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL or got %h want %h", Out_ALU, 32'hFFFFFFFF); end
  endtask

  task automatic test_shift;
    drive_op(32'h0000000F, 32'd3, 3'd4);
    n_cmp++; if (Out_ALU !== 32'h00000078) begin n_fail++; $display("FAIL sll_3 got %h want %h", Out_ALU, 32'h00000078); end
    drive_op(32'h80000000, 32'd4, 3'd6);
    n_cmp++; if (Out_ALU !== 32'hF8000000) begin n_fail++; $display("FAIL sra_4 got %h want %h", Out_ALU, 32'hF8000000); end
    drive_op(32'h80000000, 32'd4, 3'd5);
    n_cmp++; if (Out_ALU !== 32'h08000000) begin n_fail++; $display("FAIL srl_4 got %h want %h", Out_ALU, 32'h08000000); end
    drive_op(32'h0000000F, 32'd33, 3'd4);
    n_cmp++; if (Out_ALU !== 32'h0000001E) begin n_fail++; $display("FAIL sll_33 got %h want %h", Out_ALU, 32'h0000001E); end
    drive_op(32'h12345678, 32'd32, 3'd5);
    n_cmp++; if (Out_ALU !== 32'h12345678) begin n_fail++; $display("FAIL srl_0 got %h want %h", Out_ALU, 32'h12345678); end
    drive_op(32'h40000001, 32'd31, 3'd6);
    n_cmp++; if (Out_ALU !== 32'h00000000) begin n_fail++; $display("FAIL sra_31_pos got %h want %h", Out_ALU, 32'h0); end
  endtask

  task automatic test_flags;
    drive_op(32'h7FFFFFFF, 32'd1, 3'd0);
    n_cmp++; if (Out_ALU !== 32'h80000000) begin n_fail++; $display("FAIL add_ovf got %h want %h", Out_ALU, 32'h80000000); end
    n_cmp++; if ({Zero, Negative, Carry, Overflow} !== {1'b0, FL, 1'b0, FL}) begin n_fail++; $display("FAIL add_ovf_flags got %b want %b", {Zero, Negative, Carry, Overflow}, {1'b0, FL, 1'b0, FL}); end
    drive_op(32'd5, 32'd5, 3'd1);
    n_cmp++; if (Out_ALU !== 32'h0) begin n_fail++; $display("FAIL sub_zero got %h want %h", Out_ALU, 32'h0); end
    n_cmp++; if ({Zero, Negative, Carry, Overflow} !== {FL, 1'b0, FL, 1'b0}) begin n_fail++; $display("FAIL sub_zero_flags got %b want %b", {Zero, Negative, Carry, Overflow}, {FL, 1'b0, FL, 1'b0}); end
    drive_op(32'hFFFFFFFF, 32'd1, 3'd0);
    n_cmp++; if ({Out_ALU, Zero, Carry, Overflow} !== {32'h0, FL, FL, 1'b0}) begin n_fail++; $display("FAIL add_wrap got %h_%b want %h_%b", Out_ALU, {Zero, Carry, Overflow}, 32'h0, {FL, FL, 1'b0}); end
    drive_op(32'h80000000, 32'd1, 3'd1);
    n_cmp++; if ({Out_ALU, Carry, Overflow} !== {32'h7FFFFFFF, FL, FL}) begin n_fail++; $display("FAIL sub_ovf got %h_%b want %h_%b", Out_ALU, {Carry, Overflow}, 32'h7FFFFFFF, {FL, FL}); end
  endtask

  task automatic test_back_to_back;
    drive_op(32'd100, 32'd1, 3'd0);
    n_cmp++; if (Out_ALU !== 32'd101) begin n_fail++; $display("FAIL b2b_0 got %h want %h", Out_ALU, 32'd101); end
    drive_op(32'd100, 32'd1, 3'd1);
    n_cmp++; if (Out_ALU !== 32'd99) begin n_fail++; $display("FAIL b2b_1 got %h want %h", Out_ALU, 32'd99); end
    drive_op(32'hF0F0F0F0, 32'h0FF00FF0, 3'd3);
    n_cmp++; if (Out_ALU !== 32'hFF00FF00) begin n_fail++; $display("FAIL b2b_2 got %h want %h", Out_ALU, 32'hFF00FF00); end
  endtask

  task automatic test_async_reset;
    drive_op(32'h7FFFFFFF, 32'd1, 3'd0);
    #2;
    RST = 1'b1;
    #1;
    n_cmp++; if (Out_ALU !== 32'h0) begin n_fail++; $display("FAIL async_rst_out got %h want %h", Out_ALU, 32'h0); end
    n_cmp++; if ({Zero, Negative, Overflow} !== {FL, 2'b00}) begin n_fail++; $display("FAIL async_rst_flags got %b want %b", {Zero, Negative, Overflow}, {FL, 2'b00}); end
    @(posedge CLK);
    #1;
    n_cmp++; if (Out_ALU !== 32'h0) begin n_fail++; $display("FAIL rst_hold got %h want %h", Out_ALU, 32'h0); end
    @(negedge CLK);
    RST = 1'b0;
    In_A = 32'd3; In_B = 32'd4; ALUControl = 3'd0;
    @(posedge CLK);
    #1;
    n_cmp++; if (Out_ALU !== 32'd7) begin n_fail++; $display("FAIL post_rst got %h want %h", Out_ALU, 32'd7); end
  endtask

  initial begin
    test_reset();
    test_add_sub();
    test_negative();
    test_logic();
    test_shift();
    test_flags();
    test_back_to_back();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
